// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_port device: FSM state encodings
// and the width of the serial bit counter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_t;

  localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO with a combinational head. A push into a full FIFO is still taken
// when a pop happens in the same cycle.
module uart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_port.sv
// CPU-side 8N1 UART: TX FIFO feeding a serialiser, RX deserialiser feeding an
// RX FIFO, plus the DI/DO flags and sticky error bits.
module uart_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       _uart_in,
  input  logic [7:0] wr_data,
  input  logic       _adev_uart,
  output logic [7:0] rd_data,
  output logic       flag_di,
  output logic       flag_do,
  output logic       tx,
  input  logic       rx,
  output logic       tx_overrun,
  output logic       rx_overrun,
  output logic       frame_err
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);

  tx_state_t             tx_state, tx_state_n;
  logic [BAUD_W-1:0]     tx_baud, tx_baud_n;
  logic [BIT_CNT_W-1:0]  tx_bit, tx_bit_n;
  logic [7:0]            tx_shift, tx_shift_n;
  logic                  tx_q, tx_q_n;
  logic                  tx_pop;
  logic [7:0]            tx_dout;
  logic                  tx_empty, tx_full;

  rx_state_t             rx_state, rx_state_n;
  logic [BAUD_W-1:0]     rx_baud, rx_baud_n;
  logic [BIT_CNT_W-1:0]  rx_bit, rx_bit_n;
  logic [7:0]            rx_shift, rx_shift_n;
  logic [1:0]            rx_sync;
  logic                  rx_s;
  logic                  rx_push;
  logic                  rx_bad_stop;
  logic                  rx_empty, rx_full;

  assign rx_s    = rx_sync[1];
  assign tx      = tx_q;
  assign flag_di = !rx_empty;
  assign flag_do = !tx_full;

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (!_uart_in),
    .din   (wr_data),
    .pop   (tx_pop),
    .dout  (tx_dout),
    .empty (tx_empty),
    .full  (tx_full)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .din   (rx_shift),
    .pop   (!_adev_uart),
    .dout  (rd_data),
    .empty (rx_empty),
    .full  (rx_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_q     <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_baud  <= tx_baud_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      tx_q     <= tx_q_n;
    end
  end

  // The stop bit chains straight into the next start bit when data is queued.
  always_comb begin
    tx_state_n = tx_state;
    tx_baud_n  = tx_baud;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_q_n     = tx_q;
    tx_pop     = 1'b0;
    unique case (tx_state)
      IDLE: begin
        tx_q_n = 1'b1;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_dout;
          tx_baud_n  = '0;
          tx_q_n     = 1'b0;
          tx_state_n = START;
        end
      end
      START: begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud_n  = '0;
          tx_bit_n   = '0;
          tx_q_n     = tx_shift[0];
          tx_state_n = DATA;
        end else begin
          tx_baud_n = tx_baud + 1'b1;
        end
      end
      DATA: begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud_n = '0;
          if (tx_bit == '1) begin
            tx_q_n     = 1'b1;
            tx_state_n = STOP;
          end else begin
            tx_bit_n   = tx_bit + 1'b1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            tx_q_n     = tx_shift[1];
          end
        end else begin
          tx_baud_n = tx_baud + 1'b1;
        end
      end
      STOP: begin
        if (tx_baud == BAUD_LAST) begin
          tx_baud_n = '0;
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_dout;
            tx_q_n     = 1'b0;
            tx_state_n = START;
          end else begin
            tx_q_n     = 1'b1;
            tx_state_n = IDLE;
          end
        end else begin
          tx_baud_n = tx_baud + 1'b1;
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_baud  <= rx_baud_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // Samples land mid-bit: half a bit into the start bit, then whole bits.
  always_comb begin
    rx_state_n  = rx_state;
    rx_baud_n   = rx_baud;
    rx_bit_n    = rx_bit;
    rx_shift_n  = rx_shift;
    rx_push     = 1'b0;
    rx_bad_stop = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_baud_n  = '0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_baud == BAUD_HALF) begin
          rx_baud_n  = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_baud_n = rx_baud + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_baud == BAUD_LAST) begin
          rx_baud_n  = '0;
          rx_shift_n = {rx_s, rx_shift[7:1]};
          if (rx_bit == '1) begin
            rx_state_n = RX_STOP;
          end else begin
            rx_bit_n = rx_bit + 1'b1;
          end
        end else begin
          rx_baud_n = rx_baud + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_baud == BAUD_LAST) begin
          rx_baud_n = '0;
          if (rx_s) begin
            rx_push    = 1'b1;
            rx_state_n = RX_IDLE;
          end else begin
            rx_bad_stop = 1'b1;
            rx_state_n  = RX_WAIT_HIGH;
          end
        end else begin
          rx_baud_n = rx_baud + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) begin
          rx_state_n = RX_IDLE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // Synchroniser presets to the idle line level so reset never fakes a start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync    <= 2'b11;
      tx_overrun <= 1'b0;
      rx_overrun <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx};
      if (!_uart_in && tx_full && !tx_pop) begin
        tx_overrun <= 1'b1;
      end
      if (rx_push && rx_full && _adev_uart) begin
        rx_overrun <= 1'b1;
      end
      if (rx_bad_stop) begin
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_port.sv
// Directed self-checking bench for uart_port: reset state, TX framing and
// queueing, RX framing, error flags and mid-frame reset.
module tb_uart_port;

  localparam int CPB        = 16;
  localparam int DEPTH      = 4;
  localparam int PUSH_CYCLE = CPB / 2 + 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_in_n = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       adev_uart_n = 1'b1;
  logic [7:0] rd_data;
  logic       flag_di, flag_do, tx;
  logic       rx = 1'b1;
  logic       tx_overrun, rx_overrun, frame_err;

  int checks = 0;
  int failures = 0;

  logic       mon_en = 1'b0;
  logic [7:0] mon_byte;
  logic [7:0] mon_q [$];
  logic [7:0] exp_bytes [5];
  int         low_count;

  uart_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    ._uart_in   (uart_in_n),
    .wr_data    (wr_data),
    ._adev_uart (adev_uart_n),
    .rd_data    (rd_data),
    .flag_di    (flag_di),
    .flag_do    (flag_do),
    .tx         (tx),
    .rx         (rx),
    .tx_overrun (tx_overrun),
    .rx_overrun (rx_overrun),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock of CPU strobes; the strobes are sampled at exactly one rising edge.
  task automatic applyStimulus(input logic wr, input logic [7:0] data, input logic rd);
    uart_in_n   = !wr;
    wr_data     = data;
    adev_uart_n = !rd;
    @(posedge clk);
    #1;
    uart_in_n   = 1'b1;
    adev_uart_n = 1'b1;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic sendRxFrame(input logic [7:0] data, input logic stop_bit,
                             input logic rd_at_push);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    for (int c = 0; c < CPB; c++) begin
      adev_uart_n = !(rd_at_push && c == PUSH_CYCLE);
      @(posedge clk);
      #1;
    end
    adev_uart_n = 1'b1;
    rx = 1'b1;
  endtask

  // Caller sits just after the edge that started the frame.
  task automatic checkTxFrame(input logic [7:0] data);
    repeat (CPB / 2) @(posedge clk);
    #1;
    checkOutput("tx_start_mid", tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1;
      checkOutput($sformatf("tx_bit%0d", i), tx, data[i]);
    end
    repeat (CPB) @(posedge clk);
    #1;
    checkOutput("tx_stop_mid", tx, 1'b1);
    repeat (CPB / 2) @(posedge clk);
    #1;
  endtask

  initial begin : tx_monitor
    forever begin
      @(negedge clk);
      if (mon_en && tx === 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          mon_byte[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        mon_q.push_back(mon_byte);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    exp_bytes[0] = 8'h01;
    exp_bytes[1] = 8'h02;
    exp_bytes[2] = 8'h03;
    exp_bytes[3] = 8'h04;
    exp_bytes[4] = 8'h05;

    $display("[TB] reset and idle");
    resetDut();
    repeat (100) @(posedge clk);
    #1;
    checkOutput("rst_tx", tx, 1'b1);
    checkOutput("rst_flag_do", flag_do, 1'b1);
    checkOutput("rst_flag_di", flag_di, 1'b0);
    checkOutput("rst_rd_data", rd_data, 8'h00);
    checkOutput("rst_tx_overrun", tx_overrun, 1'b0);
    checkOutput("rst_rx_overrun", rx_overrun, 1'b0);
    checkOutput("rst_frame_err", frame_err, 1'b0);

    $display("[TB] single TX byte A5");
    applyStimulus(1'b1, 8'hA5, 1'b0);
    checkOutput("tx_high_after_w", tx, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("tx_low_after_w1", tx, 1'b0);
    checkTxFrame(8'hA5);
    checkOutput("tx_idle_after_160", tx, 1'b1);
    checkOutput("tx_flag_do_idle", flag_do, 1'b1);

    $display("[TB] TX queue fill and overrun");
    mon_q.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, exp_bytes[i], 1'b0);
    end
    checkOutput("txq_flag_do_before6", flag_do, 1'b0);
    checkOutput("txq_overrun_before6", tx_overrun, 1'b0);
    applyStimulus(1'b1, 8'h06, 1'b0);
    checkOutput("txq_overrun", tx_overrun, 1'b1);
    checkOutput("txq_flag_do_full", flag_do, 1'b0);
    repeat (165) @(posedge clk);
    #1;
    checkOutput("txq_flag_do_after_pop", flag_do, 1'b1);
    for (int c = 0; c < 1000 && mon_q.size() < 5; c++) begin
      @(posedge clk);
    end
    repeat (200) @(posedge clk);
    #1;
    checkOutput("txq_frame_count", mon_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < mon_q.size()) begin
        checkOutput($sformatf("txq_byte%0d", i), mon_q[i], exp_bytes[i]);
      end
    end
    mon_en = 1'b0;

    $display("[TB] RX frames 3C and C3");
    sendRxFrame(8'h3C, 1'b1, 1'b0);
    sendRxFrame(8'hC3, 1'b1, 1'b0);
    checkOutput("rx_flag_di", flag_di, 1'b1);
    checkOutput("rx_head_3c", rd_data, 8'h3C);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rx_head_c3", rd_data, 8'hC3);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rx_flag_di_empty", flag_di, 1'b0);
    checkOutput("rx_rd_data_empty", rd_data, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("rx_read_empty_ok", rx_overrun, 1'b0);

    $display("[TB] RX framing error then 7E");
    sendRxFrame(8'h55, 1'b0, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("fe_frame_err", frame_err, 1'b1);
    checkOutput("fe_no_push", flag_di, 1'b0);
    sendRxFrame(8'h7E, 1'b1, 1'b0);
    checkOutput("fe_next_flag_di", flag_di, 1'b1);
    checkOutput("fe_next_byte", rd_data, 8'h7E);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("fe_drained", flag_di, 1'b0);

    $display("[TB] RX overrun");
    sendRxFrame(8'h11, 1'b1, 1'b0);
    sendRxFrame(8'h22, 1'b1, 1'b0);
    sendRxFrame(8'h33, 1'b1, 1'b0);
    sendRxFrame(8'h44, 1'b1, 1'b0);
    checkOutput("ovr_before", rx_overrun, 1'b0);
    sendRxFrame(8'hEE, 1'b1, 1'b0);
    checkOutput("ovr_set", rx_overrun, 1'b1);
    checkOutput("ovr_head", rd_data, 8'h11);
    checkOutput("ovr_flag_di", flag_di, 1'b1);

    $display("[TB] RX full with coincident read");
    resetDut();
    checkOutput("ovr_rst_clear", rx_overrun, 1'b0);
    checkOutput("ovr_rst_empty", flag_di, 1'b0);
    sendRxFrame(8'h11, 1'b1, 1'b0);
    sendRxFrame(8'h22, 1'b1, 1'b0);
    sendRxFrame(8'h33, 1'b1, 1'b0);
    sendRxFrame(8'h44, 1'b1, 1'b0);
    sendRxFrame(8'hEE, 1'b1, 1'b1);
    checkOutput("co_no_overrun", rx_overrun, 1'b0);
    checkOutput("co_head_22", rd_data, 8'h22);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("co_head_33", rd_data, 8'h33);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("co_head_44", rd_data, 8'h44);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("co_head_ee", rd_data, 8'hEE);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("co_empty", flag_di, 1'b0);

    $display("[TB] reset mid TX frame");
    applyStimulus(1'b1, 8'h99, 1'b0);
    applyStimulus(1'b1, 8'hAA, 1'b0);
    applyStimulus(1'b1, 8'hBB, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    checkOutput("mid_tx_low", tx, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("mid_rst_tx", tx, 1'b1);
    checkOutput("mid_rst_flag_do", flag_do, 1'b1);
    checkOutput("mid_rst_flag_di", flag_di, 1'b0);
    low_count = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) low_count++;
    end
    checkOutput("mid_rst_tx_quiet", low_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
